// File: rtl/cl_pkg.sv
// Shared opcode definitions for the registered bitwise logic unit.
// Optional feature macro: CL_NAND_NOR_EN (adds the inv input to core and unit).
package cl_pkg;

   typedef logic [1:0] cl_op_t;

   localparam cl_op_t CL_AND = 2'b00;
   localparam cl_op_t CL_OR  = 2'b01;
   localparam cl_op_t CL_XOR = 2'b10;
   localparam cl_op_t CL_NOT = 2'b11;

endpackage

// File: rtl/cl_logic_core.sv
// Combinational bitwise operation selected by clop; no state.
// With CL_NAND_NOR_EN defined, inv complements the selected result.
module cl_logic_core
   import cl_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  cl_op_t           clop,
`ifdef CL_NAND_NOR_EN
   input  logic             inv,
`endif
   output logic [WIDTH-1:0] result
);

   logic [WIDTH-1:0] base_result;

   always_comb begin
      base_result = '0;
      case (clop)
         CL_AND:  base_result = a & b;
         CL_OR:   base_result = a | b;
         CL_XOR:  base_result = a ^ b;
         CL_NOT:  base_result = ~a;
         default: base_result = '0;
      endcase
   end

`ifdef CL_NAND_NOR_EN
   assign result = inv ? ~base_result : base_result;
`else
   assign result = base_result;
`endif

endmodule

// File: rtl/cl_logic_unit.sv
// Registered bitwise logic unit: one-cycle latency result, valid and zero flag.
// Optional feature macro: CL_NAND_NOR_EN (adds inv port for NAND/NOR/XNOR/pass).
module cl_logic_unit
   import cl_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  cl_op_t           clop,
`ifdef CL_NAND_NOR_EN
   input  logic             inv,
`endif
   output logic [WIDTH-1:0] out,
   output logic             out_valid,
   output logic             zero
);

   logic [WIDTH-1:0] core_result;
   logic [WIDTH-1:0] out_d, out_q;
   logic             out_valid_d, out_valid_q;
   logic             zero_d, zero_q;

   cl_logic_core #(.WIDTH(WIDTH)) u_core (
      .a      (a),
      .b      (b),
      .clop   (clop),
`ifdef CL_NAND_NOR_EN
      .inv    (inv),
`endif
      .result (core_result)
   );

   // Idle cycles keep out and zero untouched so an undriven clop never reaches the registers.
   always_comb begin
      out_d       = out_q;
      zero_d      = zero_q;
      out_valid_d = 1'b0;
      if (in_valid) begin
         out_d       = core_result;
         zero_d      = (core_result == '0);
         out_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_q       <= '0;
         out_valid_q <= 1'b0;
         zero_q      <= 1'b1;
      end else begin
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         zero_q      <= zero_d;
      end
   end

   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_cl_logic_unit.sv
// Directed-vector bench for cl_logic_unit at WIDTH=8 and WIDTH=1.
// Inverted-operation vectors run only when CL_NAND_NOR_EN is defined.
module tb_cl_logic_unit;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [1:0] clop = 2'b00;
   logic [7:0] a8 = '0, b8 = '0;
   logic [0:0] a1 = '0, b1 = '0;
`ifdef CL_NAND_NOR_EN
   logic       inv = 1'b0;
`endif

   logic [7:0] out8;
   logic       out_valid8, zero8;
   logic [0:0] out1;
   logic       out_valid1, zero1;

   int checkCount = 0;
   int errorCount = 0;

   always #5 clk = ~clk;

   cl_logic_unit #(.WIDTH(8)) dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .a         (a8),
      .b         (b8),
      .clop      (clop),
`ifdef CL_NAND_NOR_EN
      .inv       (inv),
`endif
      .out       (out8),
      .out_valid (out_valid8),
      .zero      (zero8)
   );

   cl_logic_unit #(.WIDTH(1)) dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .a         (a1),
      .b         (b1),
      .clop      (clop),
`ifdef CL_NAND_NOR_EN
      .inv       (inv),
`endif
      .out       (out1),
      .out_valid (out_valid1),
      .zero      (zero1)
   );

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of inputs, clock it in, then settle before sampling.
   task automatic applyStimulus(input logic valid, input logic [1:0] op,
                                input logic [7:0] wa, input logic [7:0] wb,
                                input logic na, input logic nb);
      in_valid = valid;
      clop     = op;
      a8       = wa;
      b8       = wb;
      a1       = na;
      b1       = nb;
      @(posedge clk);
      #1;
   endtask

   task automatic check8(input string tag, input logic [7:0] expOut,
                         input logic expValid, input logic expZero);
      checkOutput({tag, ".out8"},   64'(out8),       64'(expOut));
      checkOutput({tag, ".valid8"}, 64'(out_valid8), 64'(expValid));
      checkOutput({tag, ".zero8"},  64'(zero8),      64'(expZero));
   endtask

   task automatic check1(input string tag, input logic expOut,
                         input logic expValid, input logic expZero);
      checkOutput({tag, ".out1"},   64'(out1),       64'(expOut));
      checkOutput({tag, ".valid1"}, 64'(out_valid1), 64'(expValid));
      checkOutput({tag, ".zero1"},  64'(zero1),      64'(expZero));
   endtask

   initial begin
      rst_n = 1'b0;
      applyStimulus(1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
      applyStimulus(1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
      check8("reset", 8'h00, 1'b0, 1'b1);
      check1("reset", 1'b0, 1'b0, 1'b1);
      rst_n = 1'b1;

      // WIDTH=1 vectors; the 8-bit instance sees the same opcodes on its own operands.
      applyStimulus(1'b1, 2'b01, 8'h00, 8'h00, 1'b0, 1'b1);
      check1("w1_or", 1'b1, 1'b1, 1'b0);
      check8("w8_or_zero", 8'h00, 1'b1, 1'b1);
      applyStimulus(1'b1, 2'b10, 8'hA5, 8'hA5, 1'b1, 1'b1);
      check1("w1_xor", 1'b0, 1'b1, 1'b1);
      check8("w8_xor_self", 8'h00, 1'b1, 1'b1);
      applyStimulus(1'b1, 2'b11, 8'h00, 8'h00, 1'b0, 1'b1);
      check1("w1_not", 1'b1, 1'b1, 1'b0);
      check8("w8_not_zero", 8'hFF, 1'b1, 1'b0);

      // Opcode sweep on consecutive cycles.
      applyStimulus(1'b1, 2'b00, 8'hF0, 8'h3C, 1'b1, 1'b0);
      check8("sweep_and", 8'h30, 1'b1, 1'b0);
      check1("w1_and", 1'b0, 1'b1, 1'b1);
      applyStimulus(1'b1, 2'b01, 8'hF0, 8'h3C, 1'b0, 1'b0);
      check8("sweep_or", 8'hFC, 1'b1, 1'b0);
      check1("w1_or_zero", 1'b0, 1'b1, 1'b1);
      applyStimulus(1'b1, 2'b10, 8'hF0, 8'h3C, 1'b1, 1'b0);
      check8("sweep_xor", 8'hCC, 1'b1, 1'b0);
      check1("w1_xor_one", 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b1, 2'b11, 8'hF0, 8'h3C, 1'b1, 1'b1);
      check8("sweep_not", 8'h0F, 1'b1, 1'b0);
      check1("w1_not_a1", 1'b0, 1'b1, 1'b1);

      // Idle cycles with changing operands: results hold, valid drops.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 2'(i), 8'h00, 8'hFF, 1'b1, 1'b1);
         check8($sformatf("hold%0d", i), 8'h0F, 1'b0, 1'b0);
         check1($sformatf("hold%0d", i), 1'b0, 1'b0, 1'b1);
      end

      // Reset beats a simultaneous valid input.
      rst_n = 1'b0;
      applyStimulus(1'b1, 2'b01, 8'hFF, 8'h00, 1'b1, 1'b0);
      check8("mid_reset", 8'h00, 1'b0, 1'b1);
      check1("mid_reset", 1'b0, 1'b0, 1'b1);
      rst_n = 1'b1;
      applyStimulus(1'b1, 2'b01, 8'h55, 8'hAA, 1'b1, 1'b0);
      check8("post_reset", 8'hFF, 1'b1, 1'b0);
      check1("post_reset", 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b1, 2'b00, 8'hF0, 8'h0F, 1'b0, 1'b1);
      check8("post_reset_zero", 8'h00, 1'b1, 1'b1);
      check1("post_reset_zero", 1'b0, 1'b1, 1'b1);

`ifdef CL_NAND_NOR_EN
      inv = 1'b1;
      applyStimulus(1'b1, 2'b00, 8'hF0, 8'h3C, 1'b1, 1'b1);
      check8("nand", 8'hCF, 1'b1, 1'b0);
      check1("nand", 1'b0, 1'b1, 1'b1);
      applyStimulus(1'b1, 2'b01, 8'hF0, 8'h3C, 1'b0, 1'b0);
      check8("nor", 8'h03, 1'b1, 1'b0);
      check1("nor", 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b1, 2'b10, 8'hF0, 8'h3C, 1'b1, 1'b0);
      check8("xnor", 8'h33, 1'b1, 1'b0);
      check1("xnor", 1'b0, 1'b1, 1'b1);
      applyStimulus(1'b1, 2'b11, 8'hF0, 8'h3C, 1'b1, 1'b0);
      check8("pass_a", 8'hF0, 1'b1, 1'b0);
      check1("pass_a", 1'b1, 1'b1, 1'b0);
      inv = 1'b0;
      applyStimulus(1'b1, 2'b11, 8'hF0, 8'h3C, 1'b1, 1'b0);
      check8("inv_off", 8'h0F, 1'b1, 1'b0);
`endif

      applyStimulus(1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
